// File: rtl/temporal_sched_pkg.sv
// -----------------------------------------------------------------------------
// temporal_sched_pkg
// Shared types and helpers for the temporal unit scheduler.
//   sched_state_t : scheduler state (IDLE / RUN / HOLD)
//   sched_resp_t  : one result record {id, stamp, spike}; the fields are sized
//                   for the largest supported configuration (256 requesters,
//                   65536-cycle gamma) and users take the low bits they need
//   time_width()  : number of bits needed for a gamma-relative time
// -----------------------------------------------------------------------------
package temporal_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    localparam int RESP_ID_W   = 8;
    localparam int RESP_TIME_W = 16;

    typedef struct packed {
        logic [RESP_ID_W-1:0]   id;
        logic [RESP_TIME_W-1:0] stamp;
        logic                   spike;
    } sched_resp_t;

    function automatic int time_width(input int g);
        return (g <= 2) ? 1 : $clog2(g);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: picks the first asserted request at or after the
// rotating pointer. The pointer moves past the winner only when enable is high
// and something was granted.
//   aclk, grst : clock, asynchronous active-high reset
//   req        : request vector
//   enable     : commit the current grant (advances the pointer)
//   grant      : one-hot grant (combinational, valid whenever any_req)
//   grant_id   : index of the granted requester
//   any_req    : at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic               aclk,
    input  logic               grst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id,
    output logic               any_req
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] idx;

    // Scan the requesters starting at the pointer; the first hit wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any_req  = 1'b0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NUM_REQ);
            if (!any_req && req[idx]) begin
                any_req  = 1'b1;
                grant_id = idx;
            end
        end
        if (any_req) begin
            grant[grant_id] = 1'b1;
        end
    end

    // Pointer lands just after the last winner so it gets lowest priority next.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            ptr <= '0;
        end else if (enable && any_req) begin
            ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

endmodule

// File: rtl/temporal_unit_scheduler.sv
// -----------------------------------------------------------------------------
// temporal_unit_scheduler
// Time-shares one temporal compute unit among NUM_REQ requesters. At most one
// request is granted per gamma cycle (round-robin, at the last count of the
// cycle). During the following gamma cycle the granted spike time is turned
// into a select pulse for the unit and the first rising edge of the unit's
// output is timestamped. The result is returned on a valid/ready channel.
//   aclk, grst              : clock, asynchronous active-high reset
//   req_valid/req_time      : per-requester request and packed spike times
//   req_ready               : one-hot accept, only in boundary cycles
//   unit_select / unit_out  : temporal select to, and result from, the unit
//   resp_valid/resp_ready   : result handshake
//   resp_id/time/spike      : requester index, edge time, edge seen
//   gamma_count/gamma_start : free-running gamma position, high at count 0
// -----------------------------------------------------------------------------
module temporal_unit_scheduler
    import temporal_sched_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_REQ           = 4,
    parameter int TW                = time_width(GAMMA_CYCLE_WIDTH)
) (
    input  logic                       aclk,
    input  logic                       grst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*TW-1:0]      req_time,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       unit_select,
    input  logic                       unit_out,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [TW-1:0]              resp_time,
    output logic                       resp_spike,
    output logic [TW-1:0]              gamma_count,
    output logic                       gamma_start
);

    localparam int            IDW  = $clog2(NUM_REQ);
    localparam int            G    = GAMMA_CYCLE_WIDTH;
    localparam logic [TW-1:0] LAST = TW'(G - 1);

    sched_state_t   state;
    logic [IDW-1:0] cur_id;
    logic [TW-1:0]  cur_time;
    logic [TW-1:0]  cap_time;
    logic           cap_spike;
    logic           prev;
    sched_resp_t    resp_q;
    sched_resp_t    park;
    sched_resp_t    fin_resp;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_id;
    logic               any_req;
    logic               boundary;
    logic               slot_free;
    logic               arb_en;
    logic [TW-1:0]      granted_time;
    logic               edge_now;
    logic               fin_spike;
    logic [TW-1:0]      fin_time;
    int                 sel_last;
    logic               unused_resp_bits;

    assign boundary    = (gamma_count == LAST);
    assign gamma_start = (gamma_count == '0);
    assign slot_free   = !resp_valid || resp_ready;
    assign arb_en      = boundary && ((state == IDLE) || ((state == RUN) && slot_free));
    assign req_ready   = (arb_en && any_req) ? grant : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .aclk     (aclk),
        .grst     (grst),
        .req      (req_valid),
        .enable   (arb_en),
        .grant    (grant),
        .grant_id (grant_id),
        .any_req  (any_req)
    );

    // Pick the spike time of whichever requester the arbiter is offering.
    always_comb begin
        granted_time = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                granted_time = req_time[i*TW +: TW];
            end
        end
    end

    // Select pulse runs from t to t+PULSE_WIDTH-1 but is clipped at the end of
    // the gamma cycle so it never spills into the next one.
    always_comb begin
        sel_last = int'(cur_time) + PULSE_WIDTH - 1;
        if (sel_last > G - 1) begin
            sel_last = G - 1;
        end
        unit_select = (state == RUN) && (gamma_count >= cur_time) &&
                      (int'(gamma_count) <= sel_last);
    end

    // First rising edge of unit_out in this op, including this cycle. The
    // previous level is ignored at count 0 so a level already high when the
    // gamma cycle starts is treated as a spike at time 0.
    always_comb begin
        edge_now  = (state == RUN) && unit_out && !cap_spike &&
                    !((gamma_count != '0) && prev);
        fin_spike = cap_spike || edge_now;
        fin_time  = edge_now ? gamma_count : cap_time;
        fin_resp.id    = RESP_ID_W'(cur_id);
        fin_resp.stamp = RESP_TIME_W'(fin_time);
        fin_resp.spike = fin_spike;
    end

    assign resp_id    = resp_q.id[IDW-1:0];
    assign resp_time  = resp_q.stamp[TW-1:0];
    assign resp_spike = resp_q.spike;

    assign unused_resp_bits = ^{resp_q.id, resp_q.stamp, park.id, park.stamp};

    // Scheduler FSM plus gamma counter, capture state and response register.
    // A finished op lands in resp_q when the slot is free, otherwise it waits
    // in park (HOLD) and no further grant is made until it has been delivered.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            gamma_count <= '0;
            state       <= IDLE;
            cur_id      <= '0;
            cur_time    <= '0;
            cap_time    <= '0;
            cap_spike   <= 1'b0;
            prev        <= 1'b0;
            resp_q      <= '0;
            park        <= '0;
            resp_valid  <= 1'b0;
        end else begin
            gamma_count <= gamma_count + TW'(1);
            prev        <= unit_out;
            if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (arb_en && any_req) begin
                        cur_id    <= grant_id;
                        cur_time  <= granted_time;
                        cap_time  <= '0;
                        cap_spike <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    cap_spike <= fin_spike;
                    cap_time  <= fin_time;
                    if (boundary) begin
                        if (slot_free) begin
                            resp_q     <= fin_resp;
                            resp_valid <= 1'b1;
                            if (any_req) begin
                                cur_id    <= grant_id;
                                cur_time  <= granted_time;
                                cap_time  <= '0;
                                cap_spike <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            park  <= fin_resp;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        resp_q     <= park;
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temporal_unit_scheduler.sv
// -----------------------------------------------------------------------------
// tb_temporal_unit_scheduler
// Directed bench for temporal_unit_scheduler (G=16, PULSE_WIDTH=8, 4 requesters).
// A small unit model drives unit_out (silent, select delayed by 2, or stuck
// high). Expected responses are queued when requests are driven and checked
// as the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_temporal_unit_scheduler;

    localparam int G = 16;

    typedef struct {
        int id;
        int stamp;
        int spike;
    } exp_t;

    logic        aclk;
    logic        grst;
    logic [3:0]  req_valid;
    logic [15:0] req_time;
    logic [3:0]  req_ready;
    logic        unit_select;
    logic        unit_out;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [3:0]  resp_time;
    logic        resp_spike;
    logic [3:0]  gamma_count;
    logic        gamma_start;

    int   vectors;
    int   failures;
    int   model_count;
    int   mode;
    exp_t sb_q[$];
    logic [1:0] sh;

    temporal_unit_scheduler #(
        .GAMMA_CYCLE_WIDTH (16),
        .PULSE_WIDTH       (8),
        .NUM_REQ           (4)
    ) dut (
        .aclk        (aclk),
        .grst        (grst),
        .req_valid   (req_valid),
        .req_time    (req_time),
        .req_ready   (req_ready),
        .unit_select (unit_select),
        .unit_out    (unit_out),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_time   (resp_time),
        .resp_spike  (resp_spike),
        .gamma_count (gamma_count),
        .gamma_start (gamma_start)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Shared unit model: mode 0 never fires, mode 1 echoes select two cycles
    // late, mode 2 holds its output high.
    always @(posedge aclk or posedge grst) begin
        if (grst) sh <= 2'b00;
        else      sh <= {sh[0], unit_select};
    end
    assign unit_out = (mode == 1) ? sh[1] : (mode == 2);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] times);
        req_valid = valid;
        req_time  = times;
    endtask

    task automatic pushExp(input int id, input int stamp, input int spike);
        exp_t e;
        e.id = id;
        e.stamp = stamp;
        e.spike = spike;
        sb_q.push_back(e);
    endtask

    // Consume a handshake seen before this edge, advance one cycle, then
    // check the gamma counter against the bench's own count.
    task automatic step();
        exp_t e;
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_resp", resp_valid, 0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("resp_id", resp_id, e.id);
                checkOutput("resp_time", resp_time, e.stamp);
                checkOutput("resp_spike", resp_spike, e.spike);
            end
        end
        @(negedge aclk);
        model_count = (model_count + 1) % G;
        checkOutput("gamma_count", gamma_count, model_count);
        checkOutput("gamma_start", gamma_start, model_count == 0);
        if (req_ready !== 4'b0000) begin
            checkOutput("ready_off_boundary", model_count, G - 1);
        end
    endtask

    task automatic waitBoundary();
        for (int i = 0; i < G && model_count != G - 1; i++) step();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 64 && sb_q.size() != 0; i++) step();
        checkOutput(tag, sb_q.size(), 0);
    endtask

    task automatic applyReset();
        checkOutput("sb_empty_at_reset", sb_q.size(), 0);
        grst = 1'b1;
        applyStimulus(4'b0000, 16'h0000);
        resp_ready = 1'b1;
        mode = 1;
        #1;
        @(negedge aclk);
        checkOutput("rst_gamma_count", gamma_count, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_unit_select", unit_select, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_fields", {resp_id, resp_time, resp_spike}, 0);
        @(negedge aclk);
        grst = 1'b0;
        model_count = 0;
        checkOutput("release_gamma_start", gamma_start, 1);
    endtask

    initial begin
        vectors = 0;
        failures = 0;
        model_count = 0;
        mode = 1;
        grst = 1'b1;
        resp_ready = 1'b1;
        applyStimulus(4'b0000, 16'h0000);
        applyReset();

        // Three quiet gamma cycles.
        for (int i = 0; i < 48; i++) begin
            step();
            checkOutput("idle_select", unit_select, 0);
            checkOutput("idle_ready", req_ready, 0);
            checkOutput("idle_resp_valid", resp_valid, 0);
        end

        // req0, t=3: select 3..10, unit echoes 2 late -> edge at 5.
        applyStimulus(4'b0001, 16'h0003);
        pushExp(0, 5, 1);
        waitBoundary();
        checkOutput("grant_req0", req_ready, 4'b0001);
        step();
        applyStimulus(4'b0000, 16'h0000);
        for (int c = 0; c < G; c++) begin
            checkOutput("sel_t3", unit_select, (model_count >= 3 && model_count <= 10));
            step();
        end
        checkOutput("latency_req0", resp_valid, 1);

        // req1, t=12: pulse truncated to 12..15, edge at 14.
        applyStimulus(4'b0010, 16'h00C0);
        pushExp(1, 14, 1);
        waitBoundary();
        checkOutput("grant_req1", req_ready, 4'b0010);
        step();
        applyStimulus(4'b0000, 16'h0000);
        for (int c = 0; c < G; c++) begin
            checkOutput("sel_t12", unit_select, (model_count >= 12));
            step();
        end
        checkOutput("sel_truncated", unit_select, 0);
        checkOutput("latency_req1", resp_valid, 1);
        step();

        // All four valid from a fresh pointer: grants 0,1,2,3,0.
        applyReset();
        applyStimulus(4'b1111, 16'h4321);
        pushExp(0, 3, 1);
        pushExp(1, 4, 1);
        pushExp(2, 5, 1);
        pushExp(3, 6, 1);
        pushExp(0, 3, 1);
        for (int g = 0; g < 5; g++) begin
            waitBoundary();
            checkOutput("rr_grant", req_ready, 4'b0001 << (g % 4));
            step();
        end
        applyStimulus(4'b0000, 16'h0000);
        drain("drain_rr");

        // Unit never fires -> spike 0, time 0 (pointer now at 1).
        mode = 0;
        applyStimulus(4'b0010, 16'h0050);
        pushExp(1, 0, 0);
        waitBoundary();
        checkOutput("grant_nospike", req_ready, 4'b0010);
        step();
        applyStimulus(4'b0000, 16'h0000);
        drain("drain_nospike");

        // Unit output already high at count 0 -> spike at 0.
        mode = 2;
        applyStimulus(4'b0100, 16'h0900);
        pushExp(2, 0, 1);
        waitBoundary();
        checkOutput("grant_high", req_ready, 4'b0100);
        step();
        applyStimulus(4'b0000, 16'h0000);
        drain("drain_high");

        // Back-pressure: req3 (t=6) then req0 (t=2); the second op parks.
        mode = 1;
        resp_ready = 1'b0;
        applyStimulus(4'b1001, 16'h6002);
        pushExp(3, 8, 1);
        pushExp(0, 4, 1);
        waitBoundary();
        checkOutput("bp_grant3", req_ready, 4'b1000);
        step();
        applyStimulus(4'b0001, 16'h6002);
        waitBoundary();
        checkOutput("bp_grant0", req_ready, 4'b0001);
        step();
        applyStimulus(4'b1000, 16'h6002);
        for (int i = 0; i < 40; i++) begin
            checkOutput("hold_valid", resp_valid, 1);
            checkOutput("hold_id", resp_id, 3);
            checkOutput("hold_time", resp_time, 8);
            checkOutput("hold_spike", resp_spike, 1);
            checkOutput("hold_no_grant", req_ready, 0);
            step();
        end
        applyStimulus(4'b0000, 16'h0000);
        resp_ready = 1'b1;
        drain("drain_hold");

        // Reset in the middle of an op (req1, t=4, select high at count 6).
        applyStimulus(4'b0010, 16'h0040);
        waitBoundary();
        checkOutput("grant_before_rst", req_ready, 4'b0010);
        step();
        applyStimulus(4'b0000, 16'h0000);
        for (int i = 0; i < 6; i++) step();
        checkOutput("sel_before_rst", unit_select, 1);
        grst = 1'b1;
        #1;
        checkOutput("midrst_select", unit_select, 0);
        checkOutput("midrst_count", gamma_count, 0);
        checkOutput("midrst_gamma_start", gamma_start, 1);
        checkOutput("midrst_resp_valid", resp_valid, 0);
        checkOutput("midrst_fields", {resp_id, resp_time, resp_spike}, 0);
        applyReset();
        for (int i = 0; i < 24; i++) begin
            step();
            checkOutput("post_rst_select", unit_select, 0);
            checkOutput("post_rst_resp_valid", resp_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule

// File: doc/temporal_unit_scheduler.md
Name: temporal_unit_scheduler

Overview:
- Shares one temporal compute unit (binary-to-temporal mux style) among NUM_REQ requesters.
- Grants at most one request per gamma cycle, round-robin.
- Converts the granted binary spike time into a temporal select pulse and timestamps the unit's first rising edge. Returns the result over a valid/ready handshake.
- Also owns the free-running gamma-cycle counter for its unit.

Parameters:
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle; power of two, >= 2.
- PULSE_WIDTH, 8, length of the select pulse in aclk cycles; 1..GAMMA_CYCLE_WIDTH.
- NUM_REQ, 4, number of requesters; >= 2.
- TW, $clog2(GAMMA_CYCLE_WIDTH), derived time width; not overridden.

Ports:
- aclk  input  1  clock
- grst  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  per-requester request
- req_time  input  NUM_REQ*TW  packed spike times; requester i occupies [i*TW +: TW]
- req_ready  output  NUM_REQ  one-hot accept
- unit_select  output  1  temporal select to the shared unit
- unit_out  input  1  temporal result from the shared unit
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts
- resp_id  output  $clog2(NUM_REQ)  requester index of the result
- resp_time  output  TW  gamma-relative time of the first rising edge of unit_out
- resp_spike  output  1  1 = edge seen; 0 = no spike (resp_time = 0)
- gamma_count  output  TW  current position in the gamma cycle
- gamma_start  output  1  high while gamma_count == 0

Behaviour:
- Reset values: gamma_count 0; state IDLE; rr pointer 0; req_ready 0; unit_select 0; resp_valid/resp_id/resp_time/resp_spike 0; edge-prev flag 0.
- Reset is honoured mid-operation: in-flight op and pending response are discarded. gamma_start is high in the first cycle after release.
- gamma_count increments every aclk and wraps G-1 -> 0. "Boundary" = cycle where gamma_count == G-1.
- States: IDLE (unit unused this gamma cycle), RUN (op active this gamma cycle), HOLD (op finished, response slot blocked).
- slot_free = !resp_valid || resp_ready.
- Boundary in IDLE: if any req_valid, grant the first valid at or after the rr pointer. req_ready[g] is high combinationally in that cycle only, and the transfer happens on that edge. Latch id and time; go to RUN; pointer = g+1 mod NUM_REQ. With no request, stay IDLE.
- Boundary in RUN:
  - If slot_free: load the response register and grant the next requester as from IDLE (back-to-back RUN possible), else go to IDLE.
  - If not slot_free: park the result internally and go to HOLD; no grant.
- HOLD: on any cycle with slot_free, load the response register and go to IDLE. Grants resume only at the next boundary.
- req_ready is never high outside a boundary cycle, nor in HOLD.
- unit_select = RUN && gamma_count >= t && gamma_count <= min(t+PULSE_WIDTH-1, G-1).
  - Decoded from registered values, so no added latency.
  - The pulse is truncated at the gamma boundary and never wraps.
- Edge capture in RUN:
  - The prev flag is forced to 0 at gamma_count == 0, so a high level at count 0 counts as a spike at 0.
  - The first cycle with unit_out && !prev records gamma_count and sets the spike flag; later edges are ignored.
  - unit_out is assumed synchronous to aclk.
- The response register holds stable while resp_valid && !resp_ready. resp_valid drops the cycle after acceptance unless reloaded on that same edge.
- Latency: a grant at boundary k gives resp_valid in the first cycle of gamma cycle k+2 when the slot is free.

Decomposition:
- Package temporal_sched_pkg:
  - state enum {IDLE, RUN, HOLD};
  - function time_width(G);
  - response struct {id, time, spike}.
- Sub-module rr_arbiter (NUM_REQ, one-hot grant, pointer update on enable).

Test Plan:
- Reset release; no requests for 3 gamma cycles -> gamma_start at counts 0/16/32, unit_select and req_ready stay 0, resp_valid 0.
- req0 t=3; unit drives unit_out = select delayed 2 cycles; resp_ready=1 -> select high counts 3..10; resp id=0 time=5 spike=1 at start of the second gamma cycle after grant.
- req1 t=12 with PULSE_WIDTH=8 -> select high counts 12..15 only (truncated), low at next count 0.
- All four valid continuously, resp_ready=1 -> grants 0,1,2,3,0 on consecutive boundaries; one response per gamma cycle in the same order.
- unit_out never rises -> resp_spike=0, resp_time=0. A second test holds unit_out high from count 0 -> time=0, spike=1.
- resp_ready=0 for 40 cycles with two requests pending -> second op enters HOLD, no third grant, response fields stable. On resp_ready=1 both responses drain in order. Assert grst mid-RUN -> all outputs return to reset values immediately.
